// File: rtl/axi_sram_slave_if.sv
// AXI4 bundle: 32-bit address/data, 4-bit IDs, no sideband signals.
// The "in" modport is the responder end, "out" the requester end.
interface axi_if;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport in (
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rid, rlast, input rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready
  );

  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rid, rlast, output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, bid, output bready
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 responder over a word-addressed SRAM; one transaction at a time, FIXED/INCR bursts.
// Read data is a combinational array lookup, so R beats start one cycle after AR.
module axi_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 4096
) (
  input logic clk,
  input logic rstn,
  axi_if.in   in
);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [8:0]  beat_q, beat_d;
  logic        err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]      offset;
  logic [31:0]      addr_step;
  logic [IDX_W-1:0] idx;
  logic             beat_err, last_beat;
  logic             rd_st, wr_st, wb_st, idle_st;
  logic             ar_hs, aw_hs, r_hs, w_hs, b_hs;

  // Offset compare also rejects addresses below the base, since they wrap to huge values.
  assign offset    = addr_q - BASE_ADDR;
  assign idx       = offset[IDX_W+1:2];
  assign beat_err  = (size_q > 3'd2) | burst_q[1] | (offset >= MEM_BYTES);
  assign addr_step = (burst_q == 2'b01) ? (32'd1 << size_q) : 32'd0;
  assign last_beat = (beat_q == {1'b0, len_q});

  assign idle_st = rstn & (state_q == IDLE);
  assign rd_st   = rstn & (state_q == RD);
  assign wr_st   = rstn & (state_q == WR);
  assign wb_st   = rstn & (state_q == WB);

  assign in.arready = idle_st;
  assign in.awready = idle_st & ~in.arvalid;
  assign in.rvalid  = rd_st;
  assign in.rdata   = (rd_st & ~beat_err) ? mem[idx] : 32'd0;
  assign in.rresp   = (rd_st & beat_err) ? 2'b10 : 2'b00;
  assign in.rid     = rd_st ? id_q : 4'd0;
  assign in.rlast   = rd_st & last_beat;
  assign in.wready  = wr_st;
  assign in.bvalid  = wb_st;
  assign in.bresp   = (wb_st & err_q) ? 2'b10 : 2'b00;
  assign in.bid     = wb_st ? id_q : 4'd0;

  assign ar_hs = idle_st & in.arvalid;
  assign aw_hs = idle_st & ~in.arvalid & in.awvalid;
  assign r_hs  = rd_st & in.rready;
  assign w_hs  = wr_st & in.wvalid;
  assign b_hs  = wb_st & in.bready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d = RD;
          addr_d  = in.araddr;
          id_d    = in.arid;
          len_d   = in.arlen;
          size_d  = in.arsize;
          burst_d = in.arburst;
          beat_d  = '0;
        end else if (aw_hs) begin
          state_d = WR;
          addr_d  = in.awaddr;
          id_d    = in.awid;
          len_d   = in.awlen;
          size_d  = in.awsize;
          burst_d = in.awburst;
          beat_d  = '0;
          err_d   = 1'b0;
        end
      end
      RD: begin
        if (r_hs) begin
          beat_d = beat_q + 9'd1;
          addr_d = addr_q + addr_step;
          if (last_beat) state_d = IDLE;
        end
      end
      WR: begin
        if (w_hs) begin
          beat_d = beat_q + 9'd1;
          addr_d = addr_q + addr_step;
          if (beat_err) err_d = 1'b1;
          // wlast decides termination; a length mismatch either way is reported in B.
          if (in.wlast) begin
            if (!last_beat) err_d = 1'b1;
            state_d = WB;
          end
        end
      end
      WB: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // SRAM has no reset so contents survive an abandoned transaction.
  always_ff @(posedge clk) begin
    if (w_hs & ~beat_err) begin
      for (int i = 0; i < 4; i++) begin
        if (in.wstrb[i]) mem[idx][8*i +: 8] <= in.wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave: protocol-level reference model with a per-cycle
// compare process, plus directed cases with hand-computed expectations.
module tb_axi_sram_slave;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;
  localparam int          TMO   = 2000;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  axi_if bus();

  axi_sram_slave #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .clk (clk),
    .rstn(rstn),
    .in  (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } rbeat_t;
  typedef struct {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  logic [31:0] mdl [WORDS];
  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] rlog[$];

  bit          busy_rd = 0, busy_wr = 0, busy_b = 0, idle;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;
  logic [3:0]  last_rid, last_bid;
  logic        last_rlast;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout waiting for handshake at %0t", name, $time);
  endtask

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] size,
                                        input logic [1:0] burst, input int b);
    logic [31:0] step;
    step = (32'd1 << size) * 32'(b);
    return (burst == 2'b01) ? a + step : a;
  endfunction

  function automatic bit bbad(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] off;
    off = a - BASE;
    return (size > 3'd2) || burst[1] || (off >= 32'd16384);
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[13:2]);
  endfunction

  function automatic logic rpat(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return $urandom_range(0, 9) < 7;
  endfunction

  // Per-cycle compare against the protocol model: which channel is busy, and the queued beats.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_arready", 32'(bus.arready), 0);
      chk("rst_awready", 32'(bus.awready), 0);
      chk("rst_wready",  32'(bus.wready), 0);
      chk("rst_rvalid",  32'(bus.rvalid), 0);
      chk("rst_bvalid",  32'(bus.bvalid), 0);
      chk("rst_rlast",   32'(bus.rlast), 0);
      chk("rst_rresp",   32'(bus.rresp), 0);
      chk("rst_bresp",   32'(bus.bresp), 0);
      chk("rst_rid",     32'(bus.rid), 0);
      chk("rst_bid",     32'(bus.bid), 0);
      chk("rst_rdata",   bus.rdata, 0);
      busy_rd = 0; busy_wr = 0; busy_b = 0;
      rq.delete();
      bq.delete();
    end else begin
      idle = !busy_rd && !busy_wr && !busy_b;
      chk("arready", 32'(bus.arready), 32'(idle));
      chk("awready", 32'(bus.awready), 32'(idle && !bus.arvalid));
      chk("rvalid",  32'(bus.rvalid), 32'(busy_rd));
      chk("wready",  32'(bus.wready), 32'(busy_wr));
      chk("bvalid",  32'(bus.bvalid), 32'(busy_b));
      if (busy_rd) begin
        if (rq.size() == 0) begin
          tmo("r_model_empty");
          busy_rd = 0;
        end else begin
          chk("rdata", bus.rdata, rq[0].data);
          chk("rresp", 32'(bus.rresp), 32'(rq[0].resp));
          chk("rid",   32'(bus.rid), 32'(rq[0].id));
          chk("rlast", 32'(bus.rlast), 32'(rq[0].last));
          if (bus.rready) begin
            last_rdata = bus.rdata; last_rresp = bus.rresp;
            last_rid = bus.rid; last_rlast = bus.rlast;
            rlog.push_back(bus.rdata);
            if (rq[0].last) busy_rd = 0;
            void'(rq.pop_front());
          end
        end
      end
      if (busy_b) begin
        if (bq.size() == 0) begin
          tmo("b_model_empty");
          busy_b = 0;
        end else begin
          chk("bresp", 32'(bus.bresp), 32'(bq[0].resp));
          chk("bid",   32'(bus.bid), 32'(bq[0].id));
          if (bus.bready) begin
            last_bresp = bus.bresp; last_bid = bus.bid;
            busy_b = 0;
            void'(bq.pop_front());
          end
        end
      end
      if (busy_wr && bus.wvalid && bus.wlast) begin
        busy_wr = 0;
        busy_b = 1;
      end
      if (idle && bus.arvalid) busy_rd = 1;
      else if (idle && bus.awvalid) busy_wr = 1;
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int rmode, input int rst_after);
    int t, n, cyc;
    bit done, bad;
    logic [31:0] a;
    for (int b = 0; b <= int'(len); b++) begin
      a = baddr(addr, size, burst, b);
      bad = bbad(a, size, burst);
      rq.push_back('{bad ? 32'd0 : mdl[widx(a)], bad ? 2'b10 : 2'b00, id, b == int'(len)});
    end
    @(posedge clk); #1;
    bus.araddr = addr; bus.arid = id; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.arready && t < TMO);
    if (!bus.arready) tmo("ar_handshake");
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0; cyc = 0; done = 0; t = 0;
    forever begin
      bus.rready = rpat(rmode, cyc);
      @(negedge clk); t++;
      if (bus.rvalid && bus.rready) begin n++; done = bus.rlast; end
      if (done || t >= TMO) break;
      if (rst_after > 0 && n == rst_after) begin
        @(posedge clk); #1; rstn = 1'b0; bus.rready = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
        return;
      end
      @(posedge clk); #1; cyc++;
    end
    if (!done) tmo("r_burst");
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  // mode 0: random data, 1: every beat = dval, 2: beat b = dval + b.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [3:0] strb, input int mode, input logic [31:0] dval,
                          input bit stall);
    logic [31:0] wd[$];
    logic [31:0] a;
    bit err;
    int t;
    for (int b = 0; b < nbeats; b++)
      wd.push_back(mode == 0 ? $urandom : (mode == 1 ? dval : dval + 32'(b)));
    @(posedge clk); #1;
    bus.awaddr = addr; bus.awid = id; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!bus.awready && t < TMO);
    if (!bus.awready) tmo("aw_handshake");
    err = (nbeats - 1) != int'(len);
    for (int b = 0; b < nbeats; b++) begin
      a = baddr(addr, size, burst, b);
      if (bbad(a, size, burst)) err = 1;
      else for (int i = 0; i < 4; i++)
        if (strb[i]) mdl[widx(a)][8*i +: 8] = wd[b][8*i +: 8];
    end
    bq.push_back('{err ? 2'b10 : 2'b00, id});
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (stall && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
      bus.wvalid = 1'b1; bus.wdata = wd[b]; bus.wstrb = strb; bus.wlast = (b == nbeats - 1);
      t = 0;
      do begin @(negedge clk); t++; end while (!bus.wready && t < TMO);
      if (!bus.wready) tmo("w_beat");
      @(posedge clk); #1;
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
    end
    t = 0;
    do begin
      @(posedge clk); #1;
      bus.bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); t++;
    end while (!(bus.bvalid && bus.bready) && t < TMO);
    if (!(bus.bvalid && bus.bready)) tmo("b_handshake");
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    int          r, nb;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
    bus.rready = 0; bus.bready = 0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Fill the whole array with 256-beat bursts: word i = C000_0000 + i.
    for (int k = 0; k < 16; k++)
      do_write(BASE + 32'(k * 1024), 4'(k), 8'd255, 3'd2, 2'b01, 256, 4'hF, 2,
               32'hC000_0000 + 32'(k * 256), 0);
    chk("model_fill_word11", mdl[11], 32'hC000_000B);

    do_write(BASE, 4'h3, 8'd0, 3'd2, 2'b01, 1, 4'hF, 1, 32'h1234_5678, 0);
    chk("single_bresp", 32'(last_bresp), 0);
    chk("single_bid", 32'(last_bid), 32'h3);
    do_read(BASE, 4'h5, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("single_rdata", last_rdata, 32'h1234_5678);
    chk("single_rlast", 32'(last_rlast), 1);
    chk("single_rresp", 32'(last_rresp), 0);
    chk("single_rid", 32'(last_rid), 32'h5);

    do_write(BASE + 32'h10, 4'h1, 8'd3, 3'd2, 2'b01, 4, 4'hF, 2, 32'hA0, 1);
    rlog.delete();
    do_read(BASE + 32'h10, 4'h2, 8'd3, 3'd2, 2'b01, 1, 0);
    chk("incr_beats", 32'(rlog.size()), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) chk("incr_data", rlog[i], 32'hA0 + 32'(i));

    do_write(BASE + 32'h20, 4'h4, 8'd0, 3'd2, 2'b01, 1, 4'hF, 1, 32'h0, 0);
    do_write(BASE + 32'h20, 4'h4, 8'd0, 3'd2, 2'b01, 1, 4'b0101, 1, 32'hFFFF_FFFF, 0);
    do_read(BASE + 32'h20, 4'h4, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("strobe_rdata", last_rdata, 32'h00FF_00FF);

    fork
      do_read(BASE + 32'h40, 4'h6, 8'd3, 3'd2, 2'b01, 0, 0);
      do_write(BASE + 32'h80, 4'h7, 8'd0, 3'd2, 2'b01, 1, 4'hF, 1, 32'h5A5A_1234, 0);
      begin
        @(posedge clk); #1; @(negedge clk);
        chk("same_cycle_arready", 32'(bus.arready), 1);
        chk("same_cycle_awready", 32'(bus.awready), 0);
      end
    join
    do_read(BASE + 32'h80, 4'h7, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("after_race_rdata", last_rdata, 32'h5A5A_1234);

    do_read(32'h7FFF_FFFC, 4'h1, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("below_base_rresp", 32'(last_rresp), 2);
    chk("below_base_rdata", last_rdata, 0);
    do_write(BASE + 32'h28, 4'h2, 8'd1, 3'd2, 2'b01, 1, 4'hF, 0, 0, 0);
    chk("early_wlast_bresp", 32'(last_bresp), 2);
    do_write(BASE + 32'h30, 4'h2, 8'd0, 3'd2, 2'b01, 2, 4'hF, 0, 0, 0);
    chk("late_wlast_bresp", 32'(last_bresp), 2);
    do_write(BASE + 32'h2C, 4'h3, 8'd0, 3'd3, 2'b01, 1, 4'hF, 1, 32'hDEAD_BEEF, 0);
    chk("size3_bresp", 32'(last_bresp), 2);
    do_read(BASE + 32'h2C, 4'h3, 8'd0, 3'd2, 2'b01, 0, 0);
    chk("size3_unchanged", last_rdata, 32'hC000_000B);
    do_read(BASE + 32'h3FF8, 4'h8, 8'd3, 3'd2, 2'b01, 2, 0);
    chk("end_of_range_rresp", 32'(last_rresp), 2);
    do_read(32'hFFFF_FFF8, 4'h9, 8'd3, 3'd2, 2'b01, 2, 0);
    do_read(BASE + 32'h14, 4'hA, 8'd3, 3'd2, 2'b00, 2, 0);
    chk("fixed_rdata", last_rdata, 32'hA1);
    do_read(BASE + 32'h14, 4'hB, 8'd1, 3'd2, 2'b10, 0, 0);
    chk("wrap_rresp", 32'(last_rresp), 2);

    do_read(BASE + 32'h10, 4'hC, 8'd3, 3'd2, 2'b01, 0, 2);
    @(negedge clk);
    chk("post_reset_arready", 32'(bus.arready), 1);
    rlog.delete();
    do_read(BASE + 32'h10, 4'hD, 8'd3, 3'd2, 2'b01, 0, 0);
    chk("post_reset_beats", 32'(rlog.size()), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) chk("post_reset_data", rlog[i], 32'hA0 + 32'(i));

    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r < 7) ra = BASE + 32'($urandom_range(0, 255) << 2) + ((r == 6) ? 32'($urandom_range(0, 3)) : 32'd0);
      else if (r == 7) ra = BASE + 32'h3FF0;
      else if (r == 8) ra = 32'h7FFF_FFF0;
      else ra = 32'hFFFF_FFF8;
      rl = 8'($urandom_range(0, 7));
      rs = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      rb = (r < 8) ? 2'b01 : ((r == 8) ? 2'b00 : 2'($urandom_range(2, 3)));
      if ($urandom_range(0, 1) == 1) begin
        do_read(ra, 4'($urandom), rl, rs, rb, 2, 0);
      end else begin
        nb = int'(rl) + 1;
        r = $urandom_range(0, 7);
        if (r == 0) nb = nb + 1;
        else if (r == 1 && rl > 0) nb = nb - 1;
        do_write(ra, 4'($urandom), rl, rs, rb, nb, 4'($urandom), 0, 0, 1);
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 responder (slave end of `axi_if`, `in` modport) backed by an on-chip word-addressed SRAM array.
- Serves simulation/SoC memory for the core's AXI masters (IFU/LSU/arbiter).
- One transaction at a time, read or write. Supports FIXED and INCR bursts of up to 256 beats.
- Returns per-beat or per-burst error responses for illegal requests.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- MEM_WORDS, 4096, number of 32-bit words; power of two.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rstn  input  1  synchronous active-low reset.
- in  axi_if.in modport  (interface)  AXI4 slave bus.
  - Uses every signal of the modport: ar*/r*/aw*/w*/b* with 32-bit data/address and 4-bit IDs.

Behaviour:
- Reset, sampled at a rising edge with rstn=0:
  - state=IDLE; all counters and error flags cleared.
  - While rstn=0, outputs are forced: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rlast=0, rresp=0, bresp=0, rid=0, bid=0, rdata=0.
- Reset mid-burst: abandons the transaction, with no further beats or responses. SRAM contents are preserved; beats already written stay written.
- FSM states: IDLE, RD, WR, WB.
- IDLE:
  - arready=1.
  - awready = ~arvalid. When arvalid and awvalid are high in the same cycle, the read wins and the write waits.
  - AR handshake: latch araddr/arid/arlen/arsize/arburst into addr_q/id_q/len_q/size_q/burst_q; clear beat_q; go to RD.
  - AW handshake (only when no AR): latch the same fields from aw*; clear beat_q and err_q; go to WR.
- Beat error condition for a request: any of
  - arsize/awsize > 2;
  - burst == 2'b10 (WRAP) or 2'b11 (reserved);
  - current addr_q outside [BASE_ADDR, BASE_ADDR + 4*MEM_WORDS).
- Word index = (addr_q - BASE_ADDR) >> 2, modulo MEM_WORDS.
- RD:
  - rvalid=1 beginning the cycle after the AR handshake (latency 1).
  - rdata = mem[index]: full aligned word, or 0 when the beat is in error.
  - rresp = 2'b10 (SLVERR) on an error beat, else 2'b00.
  - rid = id_q; rlast = (beat_q == len_q).
  - rdata, rresp, rid and rlast hold stable while rvalid & ~rready.
  - On rvalid & rready: beat_q += 1. INCR: addr_q += (1 << size_q). FIXED: addr_q unchanged.
  - If rlast was high on that handshake, go to IDLE. A new AR is accepted no earlier than the next cycle.
- WR:
  - wready=1.
  - On wvalid & wready, for a non-error beat, write mem[index] byte lane i if wstrb[i]. An error beat sets err_q and writes nothing.
  - addr_q and beat_q update as for reads.
  - Burst terminates on the beat with wlast=1. If beat_q != len_q on that beat, set err_q; this covers both early and late wlast. Then go to WB.
- WB:
  - bvalid=1; bid = id_q; bresp = err_q ? 2'b10 : 2'b00.
  - Held stable until bready. On bvalid & bready go to IDLE.
- Address arithmetic: 32-bit, wraps modulo 2^32. After the wrap the address is out of range, so subsequent beats are SLVERR.
- A read that follows a write to the same address observes the written data, since the write completes before WB.
- Throughput:
  - Read: 1 beat/cycle with rready held high; burst of N beats takes N+1 cycles from AR handshake to IDLE.
  - Write: 1 beat/cycle with wvalid high, plus one B cycle.

Test Plan:
- Reset, then write 32'h1234_5678 at 0x8000_0000 (awlen=0, size=2, wstrb=4'hF), then read the same address. Expected: bresp=00 and bid=awid; rdata=32'h1234_5678, rlast=1, rresp=00, rid=arid.
- INCR read, arlen=3 at 0x8000_0010 after preloading words 4..7 = 0xA0..0xA3, with rready toggled 1,0,1,0. Expected:
  - four beats 0xA0..0xA3 in order;
  - data held during stalls;
  - rlast only on the 4th beat.
- Write with wstrb=4'b0101 and data 32'hFFFF_FFFF over a word holding 32'h0000_0000, then read it back. Expected: 32'h00FF_00FF.
- arvalid and awvalid asserted in the same cycle. Expected:
  - arready=1 and awready=0;
  - the read burst completes;
  - AW is accepted in the first IDLE cycle after rlast.
- Error cases:
  - Read at 0x7FFF_FFFC: rresp=10, rdata=0.
  - Write with awlen=1 but wlast on beat 0: bresp=10.
  - Write with awsize=3: bresp=10; memory unchanged on readback.
- rstn=0 for one cycle in the middle of a 4-beat read (after beat 1). Expected:
  - rvalid=0 on the next cycle;
  - arready=1 once rstn=1;
  - memory contents intact.
